// File: rtl/multi_rr_sched_if.sv
// multi_rr_sched_if: bundles the requester, multiplier and response signals of
// the round-robin multiplier scheduler. The scheduler connects through the
// slave modport; the requesters/multiplier environment uses the master modport.
interface multi_rr_sched_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
) ();
  localparam int IDW = $clog2(N);

  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*WIDTH-1:0]   req_a;
  logic [N*WIDTH-1:0]   req_b;
  logic                 mul_ce;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [2*WIDTH-1:0]   mul_p;
  logic [N-1:0]         rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [2*WIDTH-1:0]   rsp_p;

  modport master (
    output req_valid, req_a, req_b, mul_p,
    input  req_ready, mul_ce, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_p,
    output req_ready, mul_ce, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/multi_rr_sched.sv
// multi_rr_sched: round-robin scheduler sharing one pipelined signed multiplier
// among N requesters. One operand pair is issued per cycle; a tag pipeline
// MUL_LAT deep follows each product so it can be routed back to its owner.
// Optional feature: define MULTI_RR_BURST_EN to let the current owner keep the
// grant for up to BURST_LEN consecutive cycles before round-robin resumes.
module multi_rr_sched #(
  parameter int N         = 4,
  parameter int WIDTH     = 32,
  parameter int MUL_LAT   = 1,
  parameter int BURST_LEN = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clear_i,
  output logic           busy_o,
  multi_rr_sched_if.slave bus
);
  localparam int IDW  = $clog2(N);
  localparam int LAST = MUL_LAT - 1;

  // Reject parameter sets the scheduler was not built for at elaboration time.
  if (N < 2 || N > 8 || MUL_LAT < 1 || MUL_LAT > 4 || BURST_LEN < 1) begin : gBadParams
    $error("multi_rr_sched: illegal parameter set");
  end

  logic [IDW-1:0]   lastGrant_q, lastGrant_d;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  logic             found;
  logic             anyValid;
  logic             issue;
  logic [WIDTH-1:0] selA, selB;
  logic [MUL_LAT-1:0] tagValid_q;
  logic [IDW-1:0]     tagId_q [MUL_LAT];

`ifdef MULTI_RR_BURST_EN
  localparam int CNTW = $clog2(BURST_LEN) + 1;
  logic            ownerValid_q;
  logic [CNTW-1:0] burstCnt_q, burstCnt_d;
`endif

  // Arbitration: first valid requester after the last grant wins; the reset
  // gate keeps every issue-side output quiet while rst_ni is low.
  always_comb begin
    anyValid = |bus.req_valid;
    winner   = lastGrant_q;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(lastGrant_q) + k) % N);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`ifdef MULTI_RR_BURST_EN
    if (ownerValid_q && bus.req_valid[lastGrant_q] &&
        (burstCnt_q < CNTW'(BURST_LEN - 1))) begin
      winner = lastGrant_q;
    end
`endif
    issue       = anyValid & ~clear_i & rst_ni;
    lastGrant_d = issue ? winner : lastGrant_q;
  end

  // Issue path: forward the winner's operands to the multiplier, zero otherwise.
  always_comb begin
    selA          = '0;
    selB          = '0;
    bus.req_ready = '0;
    bus.mul_ce    = 1'b0;
    bus.mul_a     = '0;
    bus.mul_b     = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == IDW'(i)) begin
        selA = bus.req_a[i*WIDTH +: WIDTH];
        selB = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
    if (issue) begin
      bus.req_ready = N'(1) << winner;
      bus.mul_ce    = 1'b1;
      bus.mul_a     = selA;
      bus.mul_b     = selB;
    end
  end

  // Response path: the last tag stage names the owner of the product on mul_p.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_id    = '0;
    bus.rsp_p     = '0;
    if (tagValid_q[LAST]) begin
      bus.rsp_valid = N'(1) << tagId_q[LAST];
      bus.rsp_id    = tagId_q[LAST];
      bus.rsp_p     = bus.mul_p;
    end
  end

  assign busy_o = rst_ni & ((|tagValid_q) | anyValid);

  // Pointer and tag pipeline; clear drops every in-flight tag but keeps the pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lastGrant_q <= IDW'(N - 1);
      tagValid_q  <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        tagId_q[s] <= '0;
      end
    end else begin
      lastGrant_q   <= lastGrant_d;
      tagValid_q[0] <= issue;
      tagId_q[0]    <= winner;
      for (int s = 1; s < MUL_LAT; s++) begin
        tagValid_q[s] <= tagValid_q[s-1] & ~clear_i;
        tagId_q[s]    <= tagId_q[s-1];
      end
    end
  end

`ifdef MULTI_RR_BURST_EN
  // Burst length: count repeat grants to the owner; restart when the grant
  // moves, the owner drops valid, or the burst limit forces a round-robin turn.
  always_comb begin
    burstCnt_d = burstCnt_q;
    if (issue) begin
      if (ownerValid_q && (winner == lastGrant_q) &&
          (burstCnt_q < CNTW'(BURST_LEN - 1))) begin
        burstCnt_d = burstCnt_q + 1'b1;
      end else begin
        burstCnt_d = '0;
      end
    end else if (!bus.req_valid[lastGrant_q]) begin
      burstCnt_d = '0;
    end
  end

  // Burst state registers; no owner exists until the first grant after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      burstCnt_q   <= '0;
      ownerValid_q <= 1'b0;
    end else begin
      burstCnt_q   <= burstCnt_d;
      ownerValid_q <= ownerValid_q | issue;
    end
  end
`endif
endmodule

// File: tb/tb_multi_rr_sched.sv
// tb_multi_rr_sched: directed, table-driven bench for multi_rr_sched. Two
// instances share the same stimulus: dut1 with MUL_LAT=1 and dut3 with
// MUL_LAT=3, each fed by a behavioural pipelined signed multiplier.
module tb_multi_rr_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [3:0]  reqValid;
  logic [31:0] reqAVal, reqBVal;
  logic        busy1, busy3;
  int          total = 0;
  int          bad   = 0;

  multi_rr_sched_if #(.N(4), .WIDTH(32)) bus1 ();
  multi_rr_sched_if #(.N(4), .WIDTH(32)) bus3 ();

  multi_rr_sched #(.N(4), .WIDTH(32), .MUL_LAT(1), .BURST_LEN(4)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .busy_o(busy1), .bus(bus1.slave));
  multi_rr_sched #(.N(4), .WIDTH(32), .MUL_LAT(3), .BURST_LEN(4)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .busy_o(busy3), .bus(bus3.slave));

  always #5 clk = ~clk;

  // Every requester lane carries the same operands; ids tell the owners apart.
  assign bus1.req_valid = reqValid;
  assign bus1.req_a     = {4{reqAVal}};
  assign bus1.req_b     = {4{reqBVal}};
  assign bus3.req_valid = reqValid;
  assign bus3.req_a     = {4{reqAVal}};
  assign bus3.req_b     = {4{reqBVal}};

  logic signed [63:0] mulP1;
  logic signed [63:0] mulP3 [3];

  // Single-stage multiplier model for dut1: product one cycle after CE, zero without CE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mulP1 <= '0;
    else if (bus1.mul_ce) mulP1 <= 64'(signed'(bus1.mul_a)) * 64'(signed'(bus1.mul_b));
    else mulP1 <= '0;
  end
  assign bus1.mul_p = mulP1;

  // Three-stage multiplier model for dut3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mulP3[0] <= '0; mulP3[1] <= '0; mulP3[2] <= '0;
    end else begin
      if (bus3.mul_ce) mulP3[0] <= 64'(signed'(bus3.mul_a)) * 64'(signed'(bus3.mul_b));
      else mulP3[0] <= '0;
      mulP3[1] <= mulP3[0];
      mulP3[2] <= mulP3[1];
    end
  end
  assign bus3.mul_p = mulP3[2];

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  expReady;
    logic [3:0]  expRspValid;
    logic [1:0]  expRspId;
    logic [63:0] expRspP;
  } vec_t;

  vec_t       vecs [16];
  logic [3:0] burstExp [9];

  // Drive one cycle of inputs on the falling edge, then settle before sampling.
  task automatic applyStimulus(input logic [3:0] v, input logic c,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    reqValid = v;
    clear    = c;
    reqAVal  = a;
    reqBVal  = b;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reqValid = '0;
    clear    = 1'b0;
    rst_n    = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{4'b1111, 32'd2, 32'd5, 4'b0001, 4'b0000, 2'd0, 64'd0};
    vecs[1]  = '{4'b1111, 32'd2, 32'd5, 4'b0010, 4'b0001, 2'd0, 64'd10};
    vecs[2]  = '{4'b1111, 32'd2, 32'd5, 4'b0100, 4'b0010, 2'd1, 64'd10};
    vecs[3]  = '{4'b1111, 32'd2, 32'd5, 4'b1000, 4'b0100, 2'd2, 64'd10};
    vecs[4]  = '{4'b1111, 32'd2, 32'd5, 4'b0001, 4'b1000, 2'd3, 64'd10};
    vecs[5]  = '{4'b1111, 32'd2, 32'd5, 4'b0010, 4'b0001, 2'd0, 64'd10};
    vecs[6]  = '{4'b1111, 32'd2, 32'd5, 4'b0100, 4'b0010, 2'd1, 64'd10};
    vecs[7]  = '{4'b1111, 32'd2, 32'd5, 4'b1000, 4'b0100, 2'd2, 64'd10};
    vecs[8]  = '{4'b0100, 32'd7, 32'hFFFF_FFFD, 4'b0100, 4'b1000, 2'd3, 64'd10};
    vecs[9]  = '{4'b0000, 32'd0, 32'd0, 4'b0000, 4'b0100, 2'd2, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[10] = '{4'b0001, 32'h8000_0000, 32'h8000_0000, 4'b0001, 4'b0000, 2'd0, 64'd0};
    vecs[11] = '{4'b1000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 4'b0001, 2'd0, 64'h4000_0000_0000_0000};
    vecs[12] = '{4'b0000, 32'd0, 32'd0, 4'b0000, 4'b1000, 2'd3, 64'hFFFF_FFFF_8000_0001};
    vecs[13] = '{4'b0010, 32'd3, 32'd4, 4'b0010, 4'b0000, 2'd0, 64'd0};
    vecs[14] = '{4'b0010, 32'd3, 32'd4, 4'b0010, 4'b0010, 2'd1, 64'd12};
    vecs[15] = '{4'b0000, 32'd0, 32'd0, 4'b0000, 4'b0010, 2'd1, 64'd12};
`ifdef MULTI_RR_BURST_EN
    burstExp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
`else
    burstExp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif

    // Reset with every requester asking: nothing may be granted or issued.
    rst_n    = 1'b0;
    clear    = 1'b0;
    reqValid = 4'b1111;
    reqAVal  = 32'd9;
    reqBVal  = 32'd9;
    #12;
    checkOutput("rst_ready",    64'(bus1.req_ready), 64'd0);
    checkOutput("rst_mul_ce",   64'(bus1.mul_ce),    64'd0);
    checkOutput("rst_mul_a",    64'(bus1.mul_a),     64'd0);
    checkOutput("rst_rsp_valid",64'(bus1.rsp_valid), 64'd0);
    checkOutput("rst_rsp_p",    bus1.rsp_p,          64'd0);
    checkOutput("rst_busy",     64'(busy1),          64'd0);
    @(negedge clk);
    reqValid = '0;
    rst_n    = 1'b1;

    // Table: fairness, single issue, signed extremes and single-requester streaming.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].valid, 1'b0, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("v%0d_ready", i),     64'(bus1.req_ready), 64'(vecs[i].expReady));
      checkOutput($sformatf("v%0d_mul_ce", i),    64'(bus1.mul_ce),    64'(|vecs[i].valid));
      checkOutput($sformatf("v%0d_mul_a", i),     64'(bus1.mul_a),
                  (|vecs[i].valid) ? 64'(vecs[i].a) : 64'd0);
      checkOutput($sformatf("v%0d_rsp_valid", i), 64'(bus1.rsp_valid), 64'(vecs[i].expRspValid));
      checkOutput($sformatf("v%0d_rsp_id", i),    64'(bus1.rsp_id),    64'(vecs[i].expRspId));
      checkOutput($sformatf("v%0d_rsp_p", i),     bus1.rsp_p,          vecs[i].expRspP);
      checkOutput($sformatf("v%0d_busy", i),      64'(busy1),
                  64'((|vecs[i].valid) | (|vecs[i].expRspValid)));
    end

    // Latency on dut3: back-to-back issues from 1 then 3 return exactly 3 cycles later.
    doReset();
    applyStimulus(4'b1010, 1'b0, 32'd5, 32'd6);
    checkOutput("lat_ready1", 64'(bus3.req_ready), 64'b0010);
    applyStimulus(4'b1000, 1'b0, 32'd7, 32'd6);
    checkOutput("lat_ready3", 64'(bus3.req_ready), 64'b1000);
    applyStimulus(4'b0000, 1'b0, 32'd0, 32'd0);
    checkOutput("lat_early", 64'(bus3.rsp_valid), 64'd0);
    applyStimulus(4'b0000, 1'b0, 32'd0, 32'd0);
    checkOutput("lat_rsp1_valid", 64'(bus3.rsp_valid), 64'b0010);
    checkOutput("lat_rsp1_id",    64'(bus3.rsp_id),    64'd1);
    checkOutput("lat_rsp1_p",     bus3.rsp_p,          64'd30);
    applyStimulus(4'b0000, 1'b0, 32'd0, 32'd0);
    checkOutput("lat_rsp3_valid", 64'(bus3.rsp_valid), 64'b1000);
    checkOutput("lat_rsp3_id",    64'(bus3.rsp_id),    64'd3);
    checkOutput("lat_rsp3_p",     bus3.rsp_p,          64'd42);
    applyStimulus(4'b0000, 1'b0, 32'd0, 32'd0);
    checkOutput("lat_after", 64'(bus3.rsp_valid), 64'd0);

    // Flush on dut3: clear one cycle after an issue kills that tag, pointer holds.
    applyStimulus(4'b0001, 1'b0, 32'd2, 32'd3);
    checkOutput("flush_issue", 64'(bus3.req_ready), 64'b0001);
    applyStimulus(4'b0001, 1'b1, 32'd2, 32'd3);
    checkOutput("flush_ready", 64'(bus3.req_ready), 64'd0);
    checkOutput("flush_ce",    64'(bus3.mul_ce),    64'd0);
    checkOutput("flush_busy_in", 64'(busy3),        64'd1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b0000, 1'b0, 32'd0, 32'd0);
      checkOutput($sformatf("flush_rsp%0d", c), 64'(bus3.rsp_valid), 64'd0);
      checkOutput($sformatf("flush_busy%0d", c), 64'(busy3), 64'd0);
    end
    applyStimulus(4'b1111, 1'b0, 32'd1, 32'd1);
    checkOutput("flush_ptr", 64'(bus3.req_ready), 64'b0010);

    // Reset with a tag in flight on dut3: it must never be presented.
    applyStimulus(4'b0000, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b0000, 1'b0, 32'd0, 32'd0);
      checkOutput($sformatf("rstmid_rsp%0d", c), 64'(bus3.rsp_valid), 64'd0);
    end

    // Two requesters contending: pure alternation, or bursts of four when enabled.
    doReset();
    for (int c = 0; c < 9; c++) begin
      applyStimulus(4'b0011, 1'b0, 32'd1, 32'd1);
      checkOutput($sformatf("burst_grant%0d", c), 64'(bus1.req_ready), 64'(burstExp[c]));
    end

    applyStimulus(4'b0000, 1'b0, 32'd0, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_rr_sched.md
Name: multi_rr_sched

Overview:
- Round-robin scheduler that shares one registered signed multiplier among N FDTD update requesters.
- The multiplier computes P = A*B one cycle after CE is high, and clears P when CE is low.
- Issues at most one operand pair per cycle, drives the multiplier CE/A/B, tracks in-flight tags through the multiplier latency, and routes each product back to its originating requester.
- Sits in the FDTD ALU between the field-update sequencers and the shared multiplier instance.

Parameters:
- N, 4, number of requesters (2..8).
- WIDTH, 32, signed operand width; product is 2*WIDTH.
- MUL_LAT, 1, multiplier latency in cycles from CE-high to P valid (1..4).
- BURST_LEN, 4, maximum consecutive grants to one requester; used only with MULTI_RR_BURST_EN.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: drops all in-flight tags.
- req_valid  in  N  per-requester operand valid.
- req_ready  out  N  one-hot grant; transfer on req_valid[i] & req_ready[i].
- req_a  in  N*WIDTH  signed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  N*WIDTH  signed operand B, same packing as req_a.
- mul_ce  out  1  multiplier CE.
- mul_a  out  WIDTH  multiplier A.
- mul_b  out  WIDTH  multiplier B.
- mul_p  in  2*WIDTH  multiplier product P.
- rsp_valid  out  N  one-hot product valid; no backpressure.
- rsp_id  out  $clog2(N)  index of the requester that owns rsp_p.
- rsp_p  out  2*WIDTH  signed product.
- busy  out  1  high while any tag is in flight or any req_valid is high.

Behaviour:
- Reset (RST_N low, asynchronous) sets:
  - last-grant pointer to N-1, so requester 0 has first priority;
  - tag pipeline valid bits to 0;
  - burst counter to 0.
- Outputs while RST_N is low: req_ready=0, mul_ce=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_p=0, busy=0.
- Arbitration (combinational, each cycle):
  - Search starts at last_grant+1 modulo N; the first i with req_valid[i]=1 wins.
  - req_ready is one-hot for the winner, and all zeros if no req_valid is set.
  - Ready does not depend on the response path, because the multiplier is fully pipelined.
- Issue:
  - mul_ce = |req_valid and not clear; mul_a/mul_b = winner's req_a/req_b.
  - mul_a/mul_b = 0 when mul_ce=0.
- Pointer update: last_grant takes the winner index on every issue cycle, and holds otherwise.
- Tag pipeline:
  - A shift register MUL_LAT deep, each stage holding {valid, id}.
  - Stage 0 loads {mul_ce, winner} each cycle.
- Response:
  - A tag issued at cycle t reaches the last stage at t+MUL_LAT.
  - rsp_valid = onehot(id) when that stage is valid; rsp_id = id; rsp_p = mul_p.
  - rsp_p is forced to 0 and rsp_id to 0 when the stage is invalid.
- Latency: product returns MUL_LAT cycles after the accept edge. Throughput is one product per cycle.
- clear:
  - At the next edge, all tag valid bits go to 0, so in-flight products are never presented.
  - No issue happens in a clear cycle (req_ready=0).
  - The pointer is unchanged.
- Simultaneous issue and response to the same requester is legal; both handshakes occur independently.
- Reset mid-operation: in-flight tags are discarded, and no rsp_valid is produced for them after RST_N rises.
- Arithmetic:
  - Signed two's complement; the full 2*WIDTH product is passed through, with no truncation or rounding.
  - The most-negative × most-negative product is representable and must pass unchanged.
- Single-requester case: a requester holding valid alone is granted every cycle.

Optional Feature:
- Macro: MULTI_RR_BURST_EN.
- Defined:
  - The current owner keeps the grant while its req_valid stays high and the burst counter is below BURST_LEN-1.
  - The counter increments on each consecutive grant to the same owner, and resets to 0 when the grant moves or the owner drops valid.
  - After BURST_LEN consecutive grants, normal round-robin from owner+1 is forced for one arbitration.
- Undefined: pure round-robin every cycle; the burst counter logic and BURST_LEN are unused.

Test Plan:
- Single issue: requester 2 only, a=7, b=-3, N=4, MUL_LAT=1 -> req_ready=4'b0100 on that cycle; next cycle rsp_valid=4'b0100, rsp_id=2, rsp_p=-21.
- Fairness: all four req_valid held high for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; responses in the same order, one per cycle.
- Latency: MUL_LAT=3, back-to-back issues from requesters 1 and 3 -> responses exactly 3 cycles after each accept, ids 1 then 3.
- Flush: assert clear one cycle after an issue with MUL_LAT=2 -> no rsp_valid for that tag; req_ready=0 during the clear cycle.
- Extremes: a=b=-2^31 -> rsp_p=2^62; a=2^31-1, b=-1 -> rsp_p=-(2^31-1).
- Burst (MULTI_RR_BURST_EN, BURST_LEN=4): requesters 0 and 1 both valid -> grants 0,0,0,0,1,1,1,1,0.
